// File: rtl/slip_unescaper.sv
// -----------------------------------------------------------------------------
// slip_unescaper
//
// Receive-side SLIP decoder. Consumes an escaped symbol stream and emits
// decoded {data, end} symbols through a single registered output stage.
// Malformed escape sequences produce a one-cycle o_err pulse.
//
// Decoding rules:
//   NORMAL  : END -> {0, end=1}; ESC -> enter ESCAPED (no output);
//             anything else -> {symbol, end=0}
//   ESCAPED : ESC_END -> {END, 0}; ESC_ESC -> {ESC, 0};
//             END -> {0, end=1} plus error (resyncs the frame parser);
//             anything else -> dropped, error
//   Every accepted symbol in ESCAPED returns the FSM to NORMAL.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous reset, active-high
//   i_data   escaped input symbol
//   i_valid  input valid
//   o_ready  input ready (combinational from i_ready and i_rst only)
//   o_data   decoded symbol; zero when o_end=1
//   o_end    symbol is an end marker
//   o_valid  output valid
//   i_ready  downstream ready
//   o_err    one-cycle pulse after a malformed escape sequence is consumed
// -----------------------------------------------------------------------------
module slip_unescaper #(
  parameter int                      SYMBOL_WIDTH   = 8,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_END     = 8'hC0,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC     = 8'hDB,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_END = 8'hDC,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_ESC = 8'hDD
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [SYMBOL_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [SYMBOL_WIDTH-1:0] o_data,
  output logic                    o_end,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_err
);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_ESCAPED = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic                    accept;

  logic                    emit_p0;
  logic [SYMBOL_WIDTH-1:0] data_p0;
  logic                    end_p0;
  logic                    err_p0;

  logic                    vld_p1;
  logic [SYMBOL_WIDTH-1:0] data_p1;
  logic                    end_p1;
  logic                    err_p1;

  // The output register can take a new symbol whenever it is empty or is
  // being drained this cycle, giving 1 symbol/cycle without a skid buffer.
  assign o_ready = !i_rst && (!vld_p1 || i_ready);
  assign accept  = i_valid && o_ready;

  // ---- stage p0: decode the accepted symbol ----
  always_comb begin
    state_nxt = state;
    emit_p0   = 1'b0;
    data_p0   = '0;
    end_p0    = 1'b0;
    err_p0    = 1'b0;
    if (accept) begin
      case (state)
        ST_NORMAL: begin
          if (i_data == SYMBOL_END) begin
            emit_p0 = 1'b1;
            end_p0  = 1'b1;
          end else if (i_data == SYMBOL_ESC) begin
            state_nxt = ST_ESCAPED;
          end else begin
            emit_p0 = 1'b1;
            data_p0 = i_data;
          end
        end
        ST_ESCAPED: begin
          state_nxt = ST_NORMAL;
          if (i_data == SYMBOL_ESC_END) begin
            emit_p0 = 1'b1;
            data_p0 = SYMBOL_END;
          end else if (i_data == SYMBOL_ESC_ESC) begin
            emit_p0 = 1'b1;
            data_p0 = SYMBOL_ESC;
          end else if (i_data == SYMBOL_END) begin
            // Still forward the end marker so the parser drops the bad frame.
            emit_p0 = 1'b1;
            end_p0  = 1'b1;
            err_p0  = 1'b1;
          end else begin
            err_p0  = 1'b1;
          end
        end
        default: state_nxt = ST_NORMAL;
      endcase
    end
  end

  // ---- stage p1: registered output and error pulse ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_NORMAL;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      end_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state  <= state_nxt;
      err_p1 <= err_p0;
      if (emit_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        end_p1  <= end_p0;
      end else if (i_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_end   = end_p1;
  assign o_err   = err_p1;

endmodule
